// File: rtl/universal_ff_bank.sv
// WIDTH-channel flip-flop bank; each bit acts as a D, T, JK or SR flop, selected by a runtime mode register.
// Optional change counter enabled by defining UNIVERSAL_FF_CHG_CNT_EN; without it chg_cnt reads 0.
module universal_ff_bank #(
    parameter int unsigned       WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}},
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_mode,
    input  logic              en,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              err_clr,
    input  logic              cnt_clr,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  qn,
    output logic [1:0]        mode,
    output logic [WIDTH-1:0]  err,
    output logic              chg,
    output logic [CNT_W-1:0]  chg_cnt
);

    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_JK = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] err_q, err_d;
    logic [1:0]       mode_q, mode_d;
    logic             chg_q, chg_d;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] illegal;

    // q_next is evaluated with the mode already in effect, so a same-edge cfg write only affects later edges
    always_comb begin
        q_next  = q_q;
        illegal = '0;
        case (mode_q)
            MODE_D:  q_next = a;
            MODE_T:  q_next = q_q ^ a;
            MODE_JK: q_next = (a & ~q_q) | (~b & q_q);
            MODE_SR: begin
                illegal = a & b;
                q_next  = (q_q & ~(~a & b)) | (a & ~b);
            end
            default: q_next = q_q;
        endcase
    end

    always_comb begin
        mode_d = cfg_we ? cfg_mode : mode_q;
        q_d    = en ? q_next : q_q;
        err_d  = (err_clr ? '0 : err_q) | (en ? illegal : '0);
        chg_d  = (q_d != q_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q    <= RESET_VAL;
            mode_q <= MODE_D;
            err_q  <= '0;
            chg_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            mode_q <= mode_d;
            err_q  <= err_d;
            chg_q  <= chg_d;
        end
    end

`ifdef UNIVERSAL_FF_CHG_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // saturating; clear has priority over a same-edge increment
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr)
            cnt_d = '0;
        else if (chg_d && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign chg_cnt = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign chg_cnt        = '0;
`endif

    assign q    = q_q;
    assign qn   = ~q_q;
    assign mode = mode_q;
    assign err  = err_q;
    assign chg  = chg_q;

endmodule
